// File: rtl/md_sched.sv
// Multiply/divide scheduler for the E stage: owns HI/LO, sequences multi-cycle
// mult/div operations behind a busy counter and requests D-stage stalls.
module md_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_hi,
    input  logic        d_is_md,
    output logic [31:0] md_out,
    output logic        busy,
    output logic        stall_md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t        state;
    logic [CW-1:0] count;
    logic [31:0]   hi;
    logic [31:0]   lo;
    logic [31:0]   p_hi;
    logic [31:0]   p_lo;
    logic          p_skip;

    logic          is_start_op;
    logic          is_div_op;
    logic          is_signed_div;
    logic [63:0]   prod_s;
    logic [63:0]   prod_u;
    logic          a_neg;
    logic          b_neg;
    logic [31:0]   a_mag;
    logic [31:0]   b_mag;
    logic [31:0]   quo_mag;
    logic [31:0]   rem_mag;
    logic [31:0]   quo;
    logic [31:0]   rem;
    logic [63:0]   result;

    assign is_start_op   = (md_op >= OP_MULT) && (md_op <= OP_DIVU);
    assign is_div_op     = (md_op == OP_DIV) || (md_op == OP_DIVU);
    assign is_signed_div = (md_op == OP_DIV);

    // Sign-extending to 64 bits makes the low 64 bits of an unsigned multiply
    // equal to the two's-complement signed product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Signed division via magnitudes: quotient negated when signs differ,
    // remainder follows the dividend, giving truncation toward zero.
    assign a_neg   = is_signed_div & A[31];
    assign b_neg   = is_signed_div & B[31];
    assign a_mag   = a_neg ? (32'd0 - A) : A;
    assign b_mag   = b_neg ? (32'd0 - B) : B;
    assign quo_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    assign rem_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    assign quo     = (a_neg ^ b_neg) ? (32'd0 - quo_mag) : quo_mag;
    assign rem     = a_neg ? (32'd0 - rem_mag) : rem_mag;

    always_comb begin
        result = 64'd0;
        case (md_op)
            OP_MULT:          result = prod_s;
            OP_MULTU:         result = prod_u;
            OP_DIV, OP_DIVU:  result = {rem, quo};
            default:          result = 64'd0;
        endcase
    end

    // The result is captured at the start edge; the counter only models latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            busy   <= 1'b0;
            hi     <= 32'd0;
            lo     <= 32'd0;
            p_hi   <= 32'd0;
            p_lo   <= 32'd0;
            p_skip <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (is_start_op) begin
                        p_hi   <= result[63:32];
                        p_lo   <= result[31:0];
                        p_skip <= is_div_op && (B == 32'd0);
                        count  <= is_div_op ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        busy   <= 1'b1;
                        state  <= BUSY;
                    end else if (md_op == OP_MTHI) begin
                        hi <= A;
                    end else if (md_op == OP_MTLO) begin
                        lo <= A;
                    end
                end
                BUSY: begin
                    if (count == CW'(1)) begin
                        if (!p_skip) begin
                            hi <= p_hi;
                            lo <= p_lo;
                        end
                        count <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    count <= '0;
                end
            endcase
        end
    end

    assign md_out   = rd_hi ? hi : lo;
    assign stall_md = d_is_md & (busy | is_start_op);

endmodule

// File: tb/tb_md_sched.sv
// Randomized and directed bench for md_sched, checked against a cycle-count
// reference model using wide integer arithmetic.
module tb_md_sched;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk;
    logic        reset;
    logic [2:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        rd_hi;
    logic        d_is_md;
    logic [31:0] md_out;
    logic        busy;
    logic        stall_md;

    int cmp_count  = 0;
    int fail_count = 0;

    // Reference state: architectural HI/LO plus the outcome of the operation in flight.
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] m_phi;
    logic [31:0] m_plo;
    logic        m_commit;
    int          m_left;

    md_sched #(
        .MULT_CYCLES(MULT_N),
        .DIV_CYCLES (DIV_N)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .md_op   (md_op),
        .A       (A),
        .B       (B),
        .rd_hi   (rd_hi),
        .d_is_md (d_is_md),
        .md_out  (md_out),
        .busy    (busy),
        .stall_md(stall_md)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        cmp_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic model_edge(input logic [2:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic rst);
        longint sa, sb;
        logic [63:0] p;
        if (rst) begin
            m_hi = 0; m_lo = 0; m_left = 0; m_commit = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && m_commit) begin
                m_hi = m_phi;
                m_lo = m_plo;
            end
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            case (op)
                3'd1: begin
                    p = 64'(sa * sb);
                    {m_phi, m_plo} = p; m_commit = 1; m_left = MULT_N;
                end
                3'd2: begin
                    p = {32'd0, a} * {32'd0, b};
                    {m_phi, m_plo} = p; m_commit = 1; m_left = MULT_N;
                end
                3'd3: begin
                    m_commit = (b != 0); m_left = DIV_N;
                    if (b != 0) begin
                        m_plo = 32'(sa / sb);
                        m_phi = 32'(sa % sb);
                    end
                end
                3'd4: begin
                    m_commit = (b != 0); m_left = DIV_N;
                    if (b != 0) begin
                        m_plo = a / b;
                        m_phi = a % b;
                    end
                end
                3'd5: m_hi = a;
                3'd6: m_lo = a;
                default: ;
            endcase
        end
    endtask

    // One clock cycle: drive inputs, check the stall request, take the edge,
    // then check busy and both halves of md_out.
    task automatic apply_stimulus(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input logic dmd, input logic rst);
        logic exp_stall;
        md_op = op; A = a; B = b; d_is_md = dmd; reset = rst;
        #1;
        exp_stall = dmd && ((m_left > 0) || (op >= 3'd1 && op <= 3'd4));
        if (!rst) check_output("stall_md", {31'd0, stall_md}, {31'd0, exp_stall});
        @(posedge clk);
        model_edge(op, a, b, rst);
        #1;
        md_op = 3'd0; reset = 1'b0;
        check_output("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
        rd_hi = 1'b1;
        #1;
        check_output("md_out_hi", md_out, m_hi);
        rd_hi = 1'b0;
        #1;
        check_output("md_out_lo", md_out, m_lo);
    endtask

    task automatic idle_cycles(input int n, input logic dmd);
        for (int i = 0; i < n; i++) apply_stimulus(3'd0, 32'd0, 32'd0, dmd, 1'b0);
    endtask

    task automatic check_hilo(input string tag, input logic [31:0] exp_hi,
                              input logic [31:0] exp_lo);
        rd_hi = 1'b1;
        #1;
        check_output({tag, "_hi"}, md_out, exp_hi);
        rd_hi = 1'b0;
        #1;
        check_output({tag, "_lo"}, md_out, exp_lo);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 9));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a, r_b;
        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_commit = 0; m_left = 0;
        md_op = 0; A = 0; B = 0; rd_hi = 0; d_is_md = 0; reset = 1;

        apply_stimulus(3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        check_hilo("reset", 32'd0, 32'd0);

        // Signed multiply, stall held through the whole busy window.
        apply_stimulus(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1, 1'b0);
        idle_cycles(MULT_N, 1'b1);
        check_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        apply_stimulus(3'd0, 32'd0, 32'd0, 1'b1, 1'b0);

        apply_stimulus(3'd2, 32'hFFFF_FFFE, 32'h0000_0003, 1'b0, 1'b0);
        idle_cycles(MULT_N, 1'b0);
        check_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

        apply_stimulus(3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
        idle_cycles(DIV_N, 1'b0);
        check_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        apply_stimulus(3'd4, 32'd7, 32'd2, 1'b0, 1'b0);
        idle_cycles(DIV_N, 1'b0);
        check_hilo("divu", 32'd1, 32'd3);

        apply_stimulus(3'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        apply_stimulus(3'd6, 32'h9ABC_DEF0, 32'd0, 1'b0, 1'b0);
        apply_stimulus(3'd3, 32'd100, 32'd0, 1'b0, 1'b0);
        idle_cycles(DIV_N, 1'b0);
        check_hilo("div0", 32'h1234_5678, 32'h9ABC_DEF0);

        // Reset in the third busy cycle discards the pending product.
        apply_stimulus(3'd1, 32'd6, 32'd7, 1'b0, 1'b0);
        idle_cycles(2, 1'b0);
        apply_stimulus(3'd0, 32'd0, 32'd0, 1'b0, 1'b1);
        idle_cycles(MULT_N, 1'b0);
        check_hilo("reset_mid", 32'd0, 32'd0);

        apply_stimulus(3'd1, 32'd5, 32'd7, 1'b0, 1'b0);
        apply_stimulus(3'd6, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
        idle_cycles(MULT_N - 1, 1'b0);
        check_hilo("ignore", 32'd0, 32'd35);

        for (int i = 0; i < 300; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = pick_operand();
            r_b  = ($urandom_range(0, 7) == 0) ? 32'd0 : pick_operand();
            apply_stimulus(r_op, r_a, r_b, 1'($urandom_range(0, 1)),
                           ($urandom_range(0, 49) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
